// File: rtl/lfsr_gen.sv
//------------------------------------------------------------------------------
// Module   : lfsr_gen
// Brief    : Parametrised Fibonacci LFSR with seed load, zero-seed guard,
//            step counter and wrap pulse on return to the sequence origin.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_gen #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'b1000100,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_seed_err;

    logic [WIDTH-1:0] w_adv;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;
    logic             w_hit_start;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] q);
        return {q[WIDTH-2:0], ^(q & TAPS)};
    endfunction

    // STEP single shifts chained within one cycle; only the final state is used
    always_comb begin
        w_adv = r_data;
        for (int i = 0; i < STEP; i++) begin
            w_adv = f_shift(w_adv);
        end
    end

    always_comb begin
        w_seed_zero = (seed_in == c_zero);
        w_load_val  = w_seed_zero ? SEED : seed_in;
        w_hit_start = (w_adv == r_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= SEED;
            r_start    <= SEED;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
            if (load) begin
                r_data     <= w_load_val;
                r_start    <= w_load_val;
                r_count    <= '0;
                r_seed_err <= w_seed_zero;
            end else if (en) begin
                r_data <= w_adv;
                if (w_hit_start) begin
                    r_wrap  <= 1'b1;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign data_out = r_data;
    assign count    = r_count;
    assign wrap     = r_wrap;
    assign seed_err = r_seed_err;

endmodule

`default_nettype wire

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR generator that replaces the fixed 7-bit LFSR in the lab designs (random delay sources for the FSM/reaction-timer tasks). Width, tap polynomial, reset seed and shifts-per-enable are set by parameters. It adds a run-time seed load with zero-seed protection, a step counter, and a one-cycle wrap pulse when the sequence returns to its starting state. With defaults it reproduces the existing 7-bit sequence (x^7 + x^3 + 1).

## Interface
- `WIDTH`, 7: register width; legal range 3..32.
- `TAPS`, 7'b1000100: feedback mask, WIDTH bits; feedback bit = XOR-reduce(state & TAPS); bit WIDTH-1 must be 1.
- `SEED`, 1: state after reset, and substitute for an illegal zero seed; must be non-zero.
- `STEP`, 1: LFSR shifts applied per enabled cycle; legal range 1..WIDTH.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance the sequence by STEP shifts this cycle.
- `load`  in  1  load `seed_in`; has priority over `en`.
- `seed_in`  in  WIDTH  seed value sampled when `load`=1.
- `data_out`  out  WIDTH  current LFSR state.
- `count`  out  WIDTH  enabled cycles since last load/wrap/reset.
- `wrap`  out  1  one-cycle pulse: the last advance landed on the start state.
- `seed_err`  out  1  one-cycle pulse: the last load requested seed 0.

## Operation
- Single shift: next = {q[WIDTH-2:0], ^(q & TAPS)}. An advance is STEP single shifts, unrolled combinationally within one cycle.
- Internal register `start` (WIDTH) holds the current sequence origin. Reset sets it to SEED. Load sets it to the loaded value.
- Reset (async, any time including mid-load): `data_out`=SEED, `start`=SEED, `count`=0, `wrap`=0, `seed_err`=0. Takes effect immediately, independent of clk. The first edge after release behaves normally.
- Load (`load`=1, priority over `en`):
  - If `seed_in`≠0: `data_out`=`start`=`seed_in`, `seed_err`=0.
  - If `seed_in`=0: `data_out`=`start`=SEED, `seed_err`=1.
  - In both cases `count`=0 and `wrap`=0.
- Advance (`en`=1, `load`=0): `data_out`=advance(q).
  - If advance(q)==`start`: `wrap`=1 and `count`=0.
  - Otherwise: `wrap`=0 and `count`=`count`+1, wrapping modulo 2^WIDTH.
  - `seed_err`=0.
- Idle (`en`=0, `load`=0): `data_out`, `count` and `start` hold; `wrap`=0, `seed_err`=0.
- Wrap is detected only on the post-advance state. States passed through inside a STEP>1 advance are not compared.
- For a primitive TAPS with period P=2^WIDTH−1, `wrap` fires every P/gcd(P,STEP) enabled cycles.
- The all-zero state is unreachable: reset, load and the zero-seed guard never produce it, and XOR feedback never enters it.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Load and advance have 1-cycle latency: `data_out` reflects the edge at which `load`/`en` was sampled.
- `wrap` and `seed_err` are high for exactly the one cycle following the causing edge, aligned with the new `data_out`.
- Back-to-back `en` gives one advance per cycle with no bubbles.
- `load` and `en` asserted together: the load wins and no advance occurs in that cycle.
- `load` held for several cycles: the seed is reloaded every cycle and `count` stays at 0.

## Test plan
- Reset then 7× `en` (defaults) -> `data_out` sequence 0x01, 0x02, 0x04, 0x09, 0x12, 0x24, 0x49, 0x13; `count` 0..7; `wrap`=0 throughout.
- 127 consecutive `en` from reset (defaults) -> at the 127th edge `data_out`=0x01, `wrap`=1 for one cycle, `count`=0; every preceding state is unique and non-zero.
- `load`=1, `seed_in`=0x55, then one `en` -> `data_out`=0x55 with `count`=0, then 0x2A; `wrap` fires 127 enabled cycles after the load, when the state returns to 0x55.
- `load`=1, `seed_in`=0 -> `data_out`=0x01 and `seed_err`=1 for exactly one cycle; `load`+`en` asserted in the same cycle -> load wins and no advance occurs.
- STEP=2 instance: one `en` from reset -> `data_out`=0x04, `count`=1; `wrap` after 127 enabled cycles, landing on 0x01.
- Assert `rst` asynchronously between edges after 20 advances -> `data_out`=0x01, `count`=0, `wrap`=0 and `seed_err`=0 immediately, without waiting for a clock edge; normal sequence resumes after release.
